dmem_responder: RTL

//  Data-memory responder for the pipelined RISC-V core's load/store port.

---
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 load/store port: one request at a time,
// fixed wait-state latency, byte/half/word access with sign or zero extension.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_re,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int         DEPTH    = 2**ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  enter_resp;

  logic                  cap_we_q, cap_re_q;
  logic [2:0]            cap_f3_q;
  logic [ADDR_W+1:0]     cap_addr_q;
  logic [DATA_W-1:0]     cap_wdata_q;

  logic                  op_we, op_re;
  logic [2:0]            op_f3;
  logic [ADDR_W+1:0]     op_addr;
  logic [DATA_W-1:0]     op_wdata;
  logic                  op_err;

  logic                  wr_en;
  logic [3:0]            wr_be;
  logic [DATA_W-1:0]     wr_data;

  logic [DATA_W-1:0]     rd_word, rd_shift, ld_ext;

  logic [DATA_W-1:0]     mem [DEPTH];

  // Address bits above the word index alias onto the array.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Illegal funct3 for the operation, or a misaligned half/word access.
  function automatic logic access_err(input logic       we,
                                      input logic       re,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic legal, misal;
    legal = 1'b1;
    if (we)      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else if (re) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    misal = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
    return (we || re) && (!legal || misal);
  endfunction

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_re_q    <= 1'b0;
      cap_f3_q    <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req_valid) begin
        cap_we_q    <= req_we;
        cap_re_q    <= req_re;
        cap_f3_q    <= req_funct3;
        cap_addr_q  <= req_addr[ADDR_W+1:0];
        cap_wdata_q <= req_wdata;
      end
    end
  end

  // With zero wait states the write lands on the accept edge, before the
  // capture registers hold the request, so the live inputs are used then.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_we    = req_we;
      op_re    = req_re;
      op_f3    = req_funct3;
      op_addr  = req_addr[ADDR_W+1:0];
      op_wdata = req_wdata;
    end else begin
      op_we    = cap_we_q;
      op_re    = cap_re_q;
      op_f3    = cap_f3_q;
      op_addr  = cap_addr_q;
      op_wdata = cap_wdata_q;
    end
    op_err = access_err(op_we, op_re, op_f3, op_addr[1:0]);
  end

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = op_wdata;
    unique case (op_f3[1:0])
      2'd0: begin
        wr_be   = 4'b0001 << op_addr[1:0];
        wr_data = {4{op_wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = 4'b0011 << op_addr[1:0];
        wr_data = {2{op_wdata[15:0]}};
      end
      default: ;
    endcase
    // A reset arriving on the entry edge must not commit the store.
    wr_en = enter_resp && reset && op_we && !op_err;
  end

  // NOTE: the array is deliberately left out of reset; only control state is
  // cleared, and the RAM contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_be[b]) mem[op_addr[ADDR_W+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = mem[cap_addr_q[ADDR_W+1:2]];
    rd_shift = rd_word >> {cap_addr_q[1:0], 3'b000};
    case (cap_f3_q)
      3'd0:    ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd2:    ld_ext = rd_shift;
      3'd4:    ld_ext = {24'b0, rd_shift[7:0]};
      3'd5:    ld_ext = {16'b0, rd_shift[15:0]};
      default: ld_ext = '0;
    endcase
  end

  // Stores (including we=re=1) and no-ops return zero data.
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && op_err;
  assign rsp_rdata = (rsp_valid && cap_re_q && !cap_we_q && !op_err) ? ld_ext : '0;

endmodule
